mem_wb_stage: RTL and testbench

- Memory-access stage of the 64-bit lab pipeline. It sits on the consuming side of the EX/MEM stage register and produces the write-back signals for the register file.
- Decodes each EX/MEM op as store, load or nop, and drives a synchronous data memory with fixed read latency.
- Stalls upstream stages while a load is outstanding.
- Presents a registered, one-cycle write-back strobe with destination address and data.

---
 rtl/mem_wb_stage_pkg.sv | 22 ++
 rtl/mem_wb_stage_if.sv | 33 +++
 rtl/mem_wb_stage.sv | 65 ++++++
 tb/tb_mem_wb_stage.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg: shared pipeline widths, MEM/WB FSM encoding and op decode.
package mem_wb_stage_pkg;

    localparam int DEF_DATA_WIDTH     = 64;
    localparam int DEF_REG_ADDR_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        CAPTURE = 2'd2
    } state_e;

    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_LOAD  = 2'd1;
    localparam logic [1:0] OP_STORE = 2'd2;

    // A memory write wins over a register write, so both flags set is a store.
    function automatic logic [1:0] decode_op(input logic w_reg, input logic w_mem);
        return w_mem ? OP_STORE : (w_reg ? OP_LOAD : OP_NOP);
    endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: EX/MEM inputs, data-memory bus and write-back outputs of the MEM stage.
interface mem_wb_stage_if
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
    parameter int MEM_ADDR_WIDTH = 8
) ();
    logic                      w_reg_en_i;
    logic                      w_mem_en_i;
    logic [DATA_WIDTH-1:0]     r1_out_i;
    logic [DATA_WIDTH-1:0]     r2_out_i;
    logic [REG_ADDR_WIDTH-1:0] w_reg_1_i;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]     mem_din;
    logic                      mem_we;
    logic                      mem_re;
    logic [DATA_WIDTH-1:0]     mem_dout;
    logic                      stall;
    logic                      wb_en;
    logic [REG_ADDR_WIDTH-1:0] wb_addr;
    logic [DATA_WIDTH-1:0]     wb_data;

    modport slave (
        input  w_reg_en_i, w_mem_en_i, r1_out_i, r2_out_i, w_reg_1_i, mem_dout,
        output mem_addr, mem_din, mem_we, mem_re, stall, wb_en, wb_addr, wb_data
    );

    modport master (
        output w_reg_en_i, w_mem_en_i, r1_out_i, r2_out_i, w_reg_1_i, mem_dout,
        input  mem_addr, mem_din, mem_we, mem_re, stall, wb_en, wb_addr, wb_data
    );
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access stage; issues loads/stores to a fixed-latency data
// memory, stalls upstream while a load is outstanding, and registers write-back.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
    parameter int MEM_ADDR_WIDTH = 8,
    parameter int RD_LATENCY     = 2
) (
    input logic           clk,
    input logic           reset,
    mem_wb_stage_if.slave bus
);
    localparam logic [3:0] CNT_INIT = RD_LATENCY > 1 ? 4'(RD_LATENCY - 2) : 4'd0;

    state_e                    state_q;
    logic [3:0]                cnt_q;
    logic                      wb_en_q;
    logic [REG_ADDR_WIDTH-1:0] wb_addr_q;
    logic [DATA_WIDTH-1:0]     wb_data_q;
    logic [1:0]                op;
    logic                      idle;

    assign op   = decode_op(bus.w_reg_en_i, bus.w_mem_en_i);
    assign idle = state_q == IDLE;

    assign bus.mem_addr = bus.r1_out_i[MEM_ADDR_WIDTH-1:0];
    assign bus.mem_din  = bus.r2_out_i;
    assign bus.mem_we   = idle && op == OP_STORE;
    assign bus.mem_re   = idle && op == OP_LOAD;
    assign bus.stall    = bus.mem_re || state_q == RD_WAIT;
    assign bus.wb_en    = wb_en_q;
    assign bus.wb_addr  = wb_addr_q;
    assign bus.wb_data  = wb_data_q;

    // In CAPTURE the EX/MEM register still holds the load op, so w_reg_1_i is its destination.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            wb_en_q <= state_q == CAPTURE;
            unique case (state_q)
                IDLE: if (op == OP_LOAD) begin
                    state_q <= RD_LATENCY > 1 ? RD_WAIT : CAPTURE;
                    cnt_q   <= CNT_INIT;
                end
                RD_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd0) state_q <= CAPTURE;
                end
                CAPTURE: begin
                    wb_data_q <= bus.mem_dout;
                    wb_addr_q <= bus.w_reg_1_i;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed checks of mem_wb_stage at read latency 2 and 1 against
// a behavioural data memory.
module tb_mem_wb_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0;
    logic        w_reg, w_mem;
    logic [63:0] r1, r2;
    logic [2:0]  rd;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    mem_wb_stage_if ifa ();
    mem_wb_stage_if ifb ();

    mem_wb_stage #(.RD_LATENCY(2)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
    mem_wb_stage #(.RD_LATENCY(1)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

    assign ifa.w_reg_en_i = sel ? 1'b0 : w_reg;
    assign ifa.w_mem_en_i = sel ? 1'b0 : w_mem;
    assign ifa.r1_out_i   = sel ? 64'h0 : r1;
    assign ifa.r2_out_i   = sel ? 64'h0 : r2;
    assign ifa.w_reg_1_i  = sel ? 3'h0 : rd;
    assign ifb.w_reg_en_i = sel ? w_reg : 1'b0;
    assign ifb.w_mem_en_i = sel ? w_mem : 1'b0;
    assign ifb.r1_out_i   = sel ? r1 : 64'h0;
    assign ifb.r2_out_i   = sel ? r2 : 64'h0;
    assign ifb.w_reg_1_i  = sel ? rd : 3'h0;

    logic        stall, we, re, wb_en;
    logic [7:0]  maddr;
    logic [63:0] din, wb_data;
    logic [2:0]  wb_addr;
    assign stall   = sel ? ifb.stall   : ifa.stall;
    assign we      = sel ? ifb.mem_we  : ifa.mem_we;
    assign re      = sel ? ifb.mem_re  : ifa.mem_re;
    assign maddr   = sel ? ifb.mem_addr : ifa.mem_addr;
    assign din     = sel ? ifb.mem_din : ifa.mem_din;
    assign wb_en   = sel ? ifb.wb_en   : ifa.wb_en;
    assign wb_addr = sel ? ifb.wb_addr : ifa.wb_addr;
    assign wb_data = sel ? ifb.wb_data : ifa.wb_data;

    logic [63:0] mem [256];
    logic [63:0] pipe0, pipe1;
    always_ff @(posedge clk) begin
        if (we) mem[maddr] <= din;
        pipe0 <= re ? mem[maddr] : 64'h0;
        pipe1 <= pipe0;
    end
    assign ifa.mem_dout = pipe1;
    assign ifb.mem_dout = pipe0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic wr, input logic wm, input logic [63:0] a,
                          input logic [63:0] d, input logic [2:0] r);
        w_reg = wr; w_mem = wm; r1 = a; r2 = d; rd = r;
    endtask

    task automatic do_store(input logic [63:0] a, input logic [63:0] d);
        set_op(1'b0, 1'b1, a, d, 3'd0);
        #1;
        check("st_we", we, 1);
        check("st_stall", stall, 0);
        tick();
        set_op(1'b0, 1'b0, 64'h0, 64'h0, 3'd0);
        #1;
        check("st_wb_en", wb_en, 0);
    endtask

    // Leaves the bench in cycle T+lat+1 with a nop presented.
    task automatic do_load(input logic [63:0] a, input logic [2:0] r,
                           input logic [63:0] exp, input int lat);
        set_op(1'b1, 1'b0, a, 64'h0, r);
        #1;
        for (int c = 0; c < lat; c++) begin
            check("ld_stall", stall, 1);
            check("ld_re", re, c == 0);
            check("ld_we", we, 0);
            tick();
        end
        check("cap_stall", stall, 0);
        check("cap_re", re, 0);
        check("cap_wb_en", wb_en, 0);
        tick();
        set_op(1'b0, 1'b0, 64'h0, 64'h0, 3'd0);
        #1;
        check("wb_en", wb_en, 1);
        check("wb_addr", wb_addr, r);
        check("wb_data", wb_data, exp);
    endtask

    initial begin
        set_op(1'b0, 1'b0, 64'h0, 64'h0, 3'd0);
        tick();
        tick();
        check("rst_stall", stall, 0);
        check("rst_we", we, 0);
        check("rst_re", re, 0);
        check("rst_wb_en", wb_en, 0);
        check("rst_wb_addr", wb_addr, 0);
        check("rst_wb_data", wb_data, 0);
        reset = 1'b0;
        tick();
        set_op(1'b0, 1'b1, 64'h110, 64'hDEADBEEF, 3'd0);
        #1;
        check("st_addr", maddr, 8'h10);
        check("st_din", din, 64'hDEADBEEF);
        check("st_re", re, 0);
        do_store(64'h110, 64'hDEADBEEF);
        tick();
        do_store(64'h20, 64'h1234);
        tick();
        do_store(64'hF30, 64'hABCD);
        tick();
        do_load(64'h20, 3'd5, 64'h1234, 2);
        tick();
        check("wb_en_drop", wb_en, 0);
        check("wb_addr_hold", wb_addr, 5);
        check("wb_data_hold", wb_data, 64'h1234);
        do_load(64'h30, 3'd3, 64'hABCD, 2);
        set_op(1'b0, 1'b1, 64'h40, 64'h77, 3'd0);
        #1;
        check("ls_we", we, 1);
        check("ls_re", re, 0);
        tick();
        set_op(1'b0, 1'b0, 64'h0, 64'h0, 3'd0);
        #1;
        check("ls_wb_en", wb_en, 0);
        do_load(64'h10, 3'd6, 64'hDEADBEEF, 2);
        tick();
        set_op(1'b1, 1'b0, 64'h40, 64'h0, 3'd2);
        #1;
        check("rp_re", re, 1);
        tick();
        check("rp_stall_pre", stall, 1);
        reset = 1'b1;
        set_op(1'b0, 1'b0, 64'h0, 64'h0, 3'd0);
        #1;
        check("mr_stall", stall, 0);
        check("mr_we", we, 0);
        check("mr_re", re, 0);
        check("mr_wb_en", wb_en, 0);
        check("mr_wb_addr", wb_addr, 0);
        check("mr_wb_data", wb_data, 0);
        tick();
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check("rp_no_wb", wb_en, 0);
            check("rp_no_stall", stall, 0);
            tick();
        end
        do_load(64'h40, 3'd7, 64'h77, 2);
        tick();
        set_op(1'b1, 1'b1, 64'h150, 64'h99, 3'd4);
        #1;
        check("both_we", we, 1);
        check("both_re", re, 0);
        check("both_stall", stall, 0);
        tick();
        set_op(1'b0, 1'b0, 64'h0, 64'h0, 3'd0);
        #1;
        check("both_wb_en", wb_en, 0);
        tick();
        check("both_wb_en2", wb_en, 0);
        sel = 1'b1;
        tick();
        do_load(64'h50, 3'd1, 64'h99, 1);
        tick();
        check("l1_wb_en_drop", wb_en, 0);
        do_load(64'h20, 3'd2, 64'h1234, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
